// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/ready handshake, stall, flush and write-back mux.
// Defining MEM_WB_STAGE_SKID_EN adds a second (skid) entry so ready_o no longer depends on ready_i.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_wb_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [REG_W-1:0]  write_reg_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_wb_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [REG_W-1:0]  write_reg_o,
  output logic [DATA_W-1:0] wb_data_o
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  wr;
  } ent_t;

  ent_t in_ent;
  ent_t head_q, head_d;
  logic head_vld_q, head_vld_d;
  logic accept, fire;

  assign in_ent = '{ctrl: ctrl_wb_i, rd: read_data_i, alu: alu_result_i, wr: write_reg_i};

  assign valid_o = head_vld_q & ~stall_i;
  assign accept  = valid_i & ready_o;
  assign fire    = valid_o & ready_i;

  // A bubble must never assert RegWrite, so control is gated by valid_o.
  assign ctrl_wb_o    = valid_o ? head_q.ctrl : '0;
  assign read_data_o  = head_q.rd;
  assign alu_result_o = head_q.alu;
  assign write_reg_o  = head_q.wr;
  assign wb_data_o    = ctrl_wb_o[0] ? head_q.rd : head_q.alu;

`ifdef MEM_WB_STAGE_SKID_EN
  ent_t skid_q, skid_d;
  logic skid_vld_q, skid_vld_d;

  assign ready_o = ~stall_i & ~skid_vld_q;

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!stall_i) begin
      if (fire) begin
        // Skid full implies ready_o=0, so no accept can coincide with the refill.
        if (skid_vld_q) begin
          head_d     = skid_q;
          skid_vld_d = 1'b0;
        end else if (accept) begin
          head_d = in_ent;
        end else begin
          head_vld_d = 1'b0;
        end
      end else if (accept) begin
        if (head_vld_q) begin
          skid_d     = in_ent;
          skid_vld_d = 1'b1;
        end else begin
          head_d     = in_ent;
          head_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign ready_o = ~stall_i & (~head_vld_q | ready_i);

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    if (flush_i) begin
      head_vld_d = 1'b0;
    end else if (!stall_i) begin
      if (accept) begin
        head_d     = in_ent;
        head_vld_d = 1'b1;
      end else if (fire) begin
        head_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end
`endif

endmodule
